pwm_capture: RTL and testbench

Tick-qualified PWM decoder: samples an external PWM waveform, measures the high time and period between consecutive rising edges, and publishes both counts with a one-cycle valid strobe. It is the receive end of the team's PWM generator. It decodes a generator output looped back, or a PWM from another board, into duty/period values for the register interface. A watchdog flags a stuck input when no rising edge arrives in time.

---
 rtl/pwm_capture.sv | 183 ++++++++++++++++++
 tb/tb_pwm_capture.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// Purpose : tick-qualified PWM decoder. Measures high time and rising-edge to rising-edge
//           period of pwm_i and publishes them with a one-cycle valid strobe.
// Latency : results appear on the clock edge that ends the tick cycle detecting the closing
//           rising edge. pwm_i reaches the detector after SYNC_STAGES clocks.
// Backpr. : none. Strobes are single-cycle pulses and the consumer must capture them.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   tick_i         sample enable; state, counters and prev change only on tick cycles
//   pwm_i          asynchronous PWM input, synchronized internally
//   high_cnt_o     ticks sampled high in the last complete period, saturating
//   period_cnt_o   ticks in the last complete period
//   valid_o        one-cycle pulse marking new high_cnt_o/period_cnt_o
//   timeout_o      one-cycle pulse: no rising edge within the maximum period
//   stuck_high_o   input level at the last timeout, cleared by the next valid_o
//
// Optional build macro: PWM_CAPTURE_GLITCH_FILTER_EN
//   When defined, a level is accepted only after 3 consecutive tick samples agree.
//   This rejects pulses and gaps shorter than 3 ticks and delays both edges by 2 ticks.

module pwm_capture #(
    parameter int COUNTER_WIDTH = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tick_i,
    input  logic                     pwm_i,
    output logic [COUNTER_WIDTH-1:0] high_cnt_o,
    output logic [COUNTER_WIDTH:0]   period_cnt_o,
    output logic                     valid_o,
    output logic                     timeout_o,
    output logic                     stuck_high_o
);

    localparam int PW = COUNTER_WIDTH + 1;

    localparam logic [PW-1:0]            PERIOD_MAX = '1;
    localparam logic [PW-1:0]            PERIOD_ONE = PW'(1);
    localparam logic [COUNTER_WIDTH-1:0] HIGH_MAX   = '1;
    localparam logic [COUNTER_WIDTH-1:0] HIGH_ONE   = COUNTER_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer. It runs on every clock, independent of tick_i.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_raw;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
        end
    end

    assign s_raw = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Level seen by the measurement logic.
    // ------------------------------------------------------------------
    logic lvl;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // hist_q holds the two previous tick samples.
    // The accepted level changes on the tick whose sample is the third in agreement.
    // That tick is the same cycle used for detection, so the added delay is 2 ticks, not 3.
    logic [1:0] hist_q;
    logic       filt_q;

    always_comb begin
        lvl = filt_q;
        if ((s_raw == hist_q[0]) && (s_raw == hist_q[1])) begin
            lvl = s_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q <= 2'b00;
            filt_q <= 1'b0;
        end else if (tick_i) begin
            hist_q <= {hist_q[0], s_raw};
            filt_q <= lvl;
        end
    end
`else
    assign lvl = s_raw;
`endif

    // ------------------------------------------------------------------
    // Measurement FSM.
    // prev_q resets to 1, so an input that is already high at reset does not count as an edge.
    // ------------------------------------------------------------------
    state_t                   state_q;
    logic                     prev_q;
    logic [PW-1:0]            period_q;
    logic [COUNTER_WIDTH-1:0] high_q;
    logic                     rise;

    assign rise = lvl & ~prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            prev_q       <= 1'b1;
            period_q     <= '0;
            high_q       <= '0;
            high_cnt_o   <= '0;
            period_cnt_o <= '0;
            valid_o      <= 1'b0;
            timeout_o    <= 1'b0;
            stuck_high_o <= 1'b0;
        end else begin
            valid_o   <= 1'b0;
            timeout_o <= 1'b0;
            if (tick_i) begin
                prev_q <= lvl;
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_q  <= MEAS_HIGH;
                            period_q <= PERIOD_ONE;
                            high_q   <= HIGH_ONE;
                        end
                    end

                    // A rising edge cannot occur here, because prev_q is 1 throughout this state.
                    MEAS_HIGH: begin
                        if (period_q == PERIOD_MAX) begin
                            timeout_o    <= 1'b1;
                            stuck_high_o <= lvl;
                            state_q      <= IDLE;
                            period_q     <= '0;
                            high_q       <= '0;
                        end else begin
                            period_q <= period_q + PERIOD_ONE;
                            if (lvl) begin
                                if (high_q != HIGH_MAX) begin
                                    high_q <= high_q + HIGH_ONE;
                                end
                            end else begin
                                state_q <= MEAS_LOW;
                            end
                        end
                    end

                    MEAS_LOW: begin
                        if (rise) begin
                            // Close the window, publish it, and open the next window on this tick.
                            high_cnt_o   <= high_q;
                            period_cnt_o <= period_q;
                            valid_o      <= 1'b1;
                            stuck_high_o <= 1'b0;
                            period_q     <= PERIOD_ONE;
                            high_q       <= HIGH_ONE;
                            state_q      <= MEAS_HIGH;
                        end else if (period_q == PERIOD_MAX) begin
                            timeout_o    <= 1'b1;
                            stuck_high_o <= lvl;
                            state_q      <= IDLE;
                            period_q     <= '0;
                            high_q       <= '0;
                        end else begin
                            period_q <= period_q + PERIOD_ONE;
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Purpose : self-checking bench for pwm_capture. A reference model inside the bench
//           queues the expected strobes, and a monitor compares them with the DUT outputs.
// Latency : the model predicts DUT outputs for the clock edge where stimulus is sampled.
// Backpr. : not applicable.

module tb_pwm_capture;

    localparam int W    = 8;
    localparam int SS   = 2;
    localparam int PMAX = (1 << (W + 1)) - 1;
    localparam int HMAX = (1 << W) - 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           tick_i;
    logic           pwm_i;
    logic [W-1:0]   high_cnt_o;
    logic [W:0]     period_cnt_o;
    logic           valid_o;
    logic           timeout_o;
    logic           stuck_high_o;

    always #5 clk = ~clk;

    pwm_capture #(.COUNTER_WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_i       (tick_i),
        .pwm_i        (pwm_i),
        .high_cnt_o   (high_cnt_o),
        .period_cnt_o (period_cnt_o),
        .valid_o      (valid_o),
        .timeout_o    (timeout_o),
        .stuck_high_o (stuck_high_o)
    );

    typedef struct {
        bit is_to;
        int period;
        int high;
        bit lvl;
    } exp_t;

    exp_t expq[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model.
    // It works from the tick-sample stream: ticks and high samples are counted since the last
    // rising edge, and measurement is armed after the first rising edge.
    // ------------------------------------------------------------------
    bit [SS-1:0] m_sh;
    bit          m_prev, m_armed, m_s, m_lvl, m_rise;
    int          m_ticks, m_highs;
    bit [2:0]    m_last3;
    bit          m_level_keep;
    int          m_held_high, m_held_period;
    bit          m_stuck;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_sh = '0; m_prev = 1'b1; m_armed = 1'b0;
            m_ticks = 0; m_highs = 0;
            m_last3 = 3'b000; m_level_keep = 1'b0;
            m_held_high = 0; m_held_period = 0; m_stuck = 1'b0;
        end else begin
            m_s = m_sh[SS-1];
            if (tick_i) begin
                m_lvl = m_s;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
                // Keep the last three samples and follow the input only when all three agree.
                m_last3 = {m_last3[1:0], m_s};
                if (m_last3 == 3'b111) m_level_keep = 1'b1;
                else if (m_last3 == 3'b000) m_level_keep = 1'b0;
                m_lvl = m_level_keep;
`endif
                m_rise = m_lvl && !m_prev;
                if (m_armed && m_rise) begin
                    expq.push_back('{1'b0, m_ticks, (m_highs > HMAX) ? HMAX : m_highs, 1'b0});
                    m_held_period = m_ticks;
                    m_held_high   = (m_highs > HMAX) ? HMAX : m_highs;
                    m_stuck = 1'b0;
                    m_ticks = 1; m_highs = 1;
                end else if (m_armed && m_ticks == PMAX) begin
                    expq.push_back('{1'b1, 0, 0, m_lvl});
                    m_stuck = m_lvl;
                    m_armed = 1'b0;
                end else if (m_armed) begin
                    m_ticks++;
                    m_highs += int'(m_lvl);
                end else if (m_rise) begin
                    m_armed = 1'b1; m_ticks = 1; m_highs = 1;
                end
                m_prev = m_lvl;
            end
            m_sh = {m_sh[SS-2:0], pwm_i};
        end
    end

    // ------------------------------------------------------------------
    // Monitor: sample on the falling edge and pop expectations whenever the DUT strobes.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (mon_en) begin
            chk("strobes_exclusive", int'(valid_o && timeout_o), 0);
            if (valid_o || timeout_o) begin
                if (expq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_strobe: got valid=%0d timeout=%0d expected none at %0t",
                             valid_o, timeout_o, $time);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("strobe_kind_timeout", int'(timeout_o), int'(e.is_to));
                    if (!e.is_to) begin
                        chk("period_cnt", int'(period_cnt_o), e.period);
                        chk("high_cnt", int'(high_cnt_o), e.high);
                    end else begin
                        chk("timeout_stuck_level", int'(stuck_high_o), int'(e.lvl));
                    end
                end
            end else if (expq.size() != 0) begin
                tests++; fails++;
                $display("FAIL missed_strobe: got no strobe expected %s at %0t",
                         expq[0].is_to ? "timeout" : "valid", $time);
                void'(expq.pop_front());
            end
            chk("high_hold", int'(high_cnt_o), m_held_high);
            chk("period_hold", int'(period_cnt_o), m_held_period);
            chk("stuck_high", int'(stuck_high_o), int'(m_stuck));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus.
    // The waveform is defined in ticks: high for ph < hi, plus an optional one-tick glitch at ph == glitch.
    // tick_div > 0 gives a tick every tick_div cycles; tick_div == 0 gives random ticks.
    // ------------------------------------------------------------------
    task automatic run(input int per, input int hi, input int glitch, input int tick_div,
                       input int cycles, input int stall_at, input int stall_len);
        int ph;
        ph = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            if (tick_div > 0) tick_i = ((c % tick_div) == 0);
            else              tick_i = ($urandom_range(0, 1) == 1);
            if (c >= stall_at && c < stall_at + stall_len) tick_i = 1'b0;
            pwm_i = (ph < hi) || (ph == glitch);
            if (tick_i) ph = (ph + 1) % per;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; tick_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; tick_i = 1'b0; pwm_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Generator-style waveform, period 256 ticks with 192 high.
        run(256, 192, -1, 1, 1300, -1, 0);
        // Stuck high, then stuck low: one timeout each.
        run(20, 10, -1, 1, 200, -1, 0);
        run(1, 1, -1, 1, 700, -1, 0);
        run(20, 10, -1, 1, 200, -1, 0);
        run(1, 0, -1, 1, 700, -1, 0);
        // A tick every 4th cycle, 10 high / 20 low, with a 100-cycle tick stall.
        run(30, 10, -1, 4, 700, 362, 100);
        // Reset during the low phase of a 40-tick period.
        run(40, 10, -1, 1, 140, -1, 0);
        pulse_reset();
        run(40, 10, -1, 1, 200, -1, 0);
        // One-tick glitch inside the low gap.
        run(40, 10, 25, 1, 300, -1, 0);
        // Period boundaries: 511 is published, 512 times out.
        run(511, 100, -1, 1, 1600, -1, 0);
        run(512, 100, -1, 1, 1700, -1, 0);
        // High-count saturation.
        run(400, 350, -1, 1, 1300, -1, 0);
        // Random waveforms with random tick spacing.
        for (int i = 0; i < 6; i++) begin
            int p, h;
            p = $urandom_range(2, 600);
            h = $urandom_range(0, p);
            run(p, h, -1, 0, 2000, -1, 0);
        end

        @(posedge clk); #1 tick_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
